// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer: up/down count, rotate and bounce scan
// Optional manual advance input step_i is enabled by defining LED_SEQ_STEP_EN.
module led_sequencer #(
   parameter int WIDTH      = 6,
   parameter int TICK_DIV   = 13500000,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
`ifdef LED_SEQ_STEP_EN
   input  logic             step_i,
`endif
   output logic [WIDTH-1:0] led_output,
   output logic             tick_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]    CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic {SCAN_L = 1'b0, SCAN_R = 1'b1} dir_t;

   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] pat, pat_nxt;
   logic [1:0]       mode_q;
   dir_t             dir, dir_nxt;
   logic             tick, step, mode_chg, tick_nxt;

   assign tick     = en && (cnt == CNT_MAX);
   assign mode_chg = (mode != mode_q);
`ifdef LED_SEQ_STEP_EN
   assign step = tick || step_i;
`else
   assign step = tick;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         pat    <= '0;
         mode_q <= 2'd0;
         dir    <= SCAN_L;
         tick_o <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         pat    <= pat_nxt;
         mode_q <= mode;
         dir    <= dir_nxt;
         tick_o <= tick_nxt;
      end
   end

   // A mode change reloads the pattern and suppresses any coincident step.
   always_comb begin
      cnt_nxt  = cnt;
      pat_nxt  = pat;
      dir_nxt  = dir;
      tick_nxt = 1'b0;
      if (mode_chg) begin
         cnt_nxt = '0;
         dir_nxt = SCAN_L;
         pat_nxt = mode[1] ? ONE : '0;
      end else begin
         if (step) begin
            cnt_nxt = '0;
         end else if (en) begin
            cnt_nxt = cnt + CW'(1);
         end
         if (step) begin
            tick_nxt = 1'b1;
            case (mode_q)
               2'd0: pat_nxt = pat + ONE;
               2'd1: pat_nxt = pat - ONE;
               default: begin
                  // Scan modes never show a blank or multi-hot pattern.
                  if (!$onehot(pat)) begin
                     pat_nxt = ONE;
                     dir_nxt = SCAN_L;
                  end else if (mode_q == 2'd2) begin
                     pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};
                  end else if (dir == SCAN_L) begin
                     pat_nxt = pat << 1;
                     if (pat_nxt[WIDTH-1]) dir_nxt = SCAN_R;
                  end else begin
                     pat_nxt = pat >> 1;
                     if (pat_nxt[0]) dir_nxt = SCAN_L;
                  end
               end
            endcase
         end
      end
   end

   assign led_output = ACTIVE_LOW ? ~pat : pat;
endmodule
